fa_bist: RTL
============

# fa_bist

Hardware built-in self-test (BIST) controller for the single-bit full adder `fa`. It is the response-side counterpart of the full-adder stimulus sweep. On request, it drives all eight `{A,B,C_in}` vectors into an `fa` instance in ascending order and samples `S`/`C` after a programmable settle time. It compares each sample against a golden model and reports pass/fail, an error count and the first failing vector. It sits beside an `fa` instance and is the on-chip replacement for the simulation-only sweep.

## Interface
- `SETTLE`, default 1: cycles the vector is held before sampling (≥1).
- `PASSES`, default 1: number of full 8-vector sweeps per run (≥1).

- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  run request; sampled only in IDLE or DONE.
- `fa_A`  out  1  registered A drive to the adder under test.
- `fa_B`  out  1  registered B drive.
- `fa_C_in`  out  1  registered C_in drive.
- `fa_S`  in  1  sum returned by the adder under test.
- `fa_C`  in  1  carry returned by the adder under test.
- `busy`  out  1  high from the cycle after accepted `start` until DONE is entered.
- `done`  out  1  high while in DONE.
- `pass`  out  1  valid with `done`; 1 iff no mismatch occurred in the run.
- `err_count`  out  4  mismatches this run, saturating at 15.
- `first_fail_vec`  out  3  `{A,B,C_in}` of the first mismatch.
- `first_fail_resp`  out  2  observed `{C,S}` at the first mismatch.

## Operation
- FSM states: IDLE, APPLY, SAMPLE, DONE.
- **IDLE:** outputs hold. `start`=1 moves to APPLY with the following actions:
  - vector=0, pass counter=0, settle counter=0
  - `err_count`, `first_fail_*` cleared to 0
  - `busy`=1
- **APPLY:**
  - `{fa_A,fa_B,fa_C_in}` = vector.
  - The settle counter increments each cycle; at `SETTLE`-1 the FSM goes to SAMPLE.
- **SAMPLE:**
  - expected `{C,S}` = `A+B+C_in` (2-bit sum); compare against `{fa_C,fa_S}`.
  - On mismatch, `err_count` increments (saturating).
  - On the first mismatch of the run (`err_count` was 0), `first_fail_vec`/`first_fail_resp` latch.
  - Next state:
    - vector<7: vector+1, then APPLY.
    - vector=7 and not the last pass: vector wraps to 0, pass+1, then APPLY.
    - vector=7 and last pass: go to DONE.
- **DONE:**
  - `done`=1, `busy`=0, `pass`=(`err_count`==0), the drive vector is held.
  - `start`=1 restarts exactly as from IDLE (statistics cleared).
- `start` in APPLY/SAMPLE is ignored; the run is not restarted or extended.
- `err_count` saturation:
  - 15 stays 15.
  - The first-fail registers never update after the first latch.
- `rst` at any time, including mid-run, takes effect at the next edge. The FSM goes to IDLE and every output takes its reset value.

## Timing
- Reset values: `fa_A`=`fa_B`=`fa_C_in`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_fail_vec`=0, `first_fail_resp`=0.
- Start edge E0, with `start` high in IDLE/DONE. From the next cycle on, `busy`=1 and vector 0 is driven.
- Vector k is driven for exactly `SETTLE`+1 cycles. Sampling happens in its final cycle.
- `done` rises 8·`PASSES`·(`SETTLE`+1) edges after E0; `busy` falls on the same edge.
- With defaults, this is 16 cycles.
- `err_count`/`first_fail_*` update on the edge that leaves SAMPLE.
- `pass` is valid in the same cycle `done` rises.
- The adder under test is combinational. `SETTLE`≥1 guarantees sampling at least one full cycle after the registered drive changes.

## Structure
- Package `fa_bist_pkg`: state enum (IDLE/APPLY/SAMPLE/DONE), `NUM_VECTORS`=8, `ERR_MAX`=15, and function `fa_expected(vec)` returning `{C,S}`.
- The settle-counter width is derived from `SETTLE` via `$clog2`; the pass-counter width is derived from `PASSES`.
- One sub-module: `fa_bist_checker`. It is combinational: compare, plus the saturating increment and first-fail capture enables. The FSM and counters live in `fa_bist`.
- The bench instantiates `fa_bist` plus an `fa` (or a fault-injected variant) on the `fa_*` ports.

## Test plan
- Good `fa`, defaults, `start` pulse → `done` after 16 cycles, `pass`=1, `err_count`=0, vectors driven 000→111 in order.
- Carry stuck-at-0 → `err_count`=4 (vectors 011, 101, 110, 111), `first_fail_vec`=3'b011, `first_fail_resp`=2'b00, `pass`=0.
- `S` inverted, `PASSES`=3 → 24 mismatches saturate: `err_count`=15, `first_fail_vec`=3'b000, `first_fail_resp`=2'b01; `done` after 48 cycles.
- `start` reasserted at cycle 5 of a run → ignored; `done` still at cycle 16. `start` in DONE → stats cleared and a new 16-cycle run begins.
- `rst` asserted during SAMPLE of vector 4 → next cycle: IDLE, all outputs at reset values, no further vector changes until `start`.
- `SETTLE`=3, good `fa` → each vector held 4 cycles, `done` at cycle 32, `pass`=1.

Source files
------------

// File: rtl/fa_bist_pkg.sv
// Shared types and helpers for the full-adder BIST controller.
package fa_bist_pkg;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    SAMPLE,
    DONE
  } state_e;

  localparam int         NUM_VECTORS = 8;
  localparam logic [3:0] ERR_MAX     = 4'd15;

  // Golden full-adder response {C,S} for a {A,B,C_in} vector.
  function automatic logic [1:0] fa_expected(input logic [2:0] vec);
    return {1'b0, vec[2]} + {1'b0, vec[1]} + {1'b0, vec[0]};
  endfunction

endpackage

// File: rtl/fa_bist_checker.sv
// Combinational response check: compares the sampled adder output with the
// golden value and produces the saturated error count and first-fail enable.
module fa_bist_checker
  import fa_bist_pkg::*;
(
  input  logic [2:0] vec,
  input  logic       fa_s,
  input  logic       fa_c,
  input  logic [3:0] err_count,
  output logic [3:0] err_count_next,
  output logic       capture
);

  logic mismatch;

  always_comb begin
    mismatch       = ({fa_c, fa_s} != fa_expected(vec));
    err_count_next = err_count;
    if (mismatch && (err_count != ERR_MAX)) begin
      err_count_next = err_count + 4'd1;
    end
    // Only the very first mismatch of a run is recorded.
    capture = mismatch && (err_count == 4'd0);
  end

endmodule

// File: rtl/fa_bist.sv
// BIST controller: sweeps all {A,B,C_in} vectors into an external full adder,
// samples the response after SETTLE cycles and accumulates pass/fail stats.
module fa_bist
  import fa_bist_pkg::*;
#(
  parameter int SETTLE = 1,
  parameter int PASSES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       fa_A,
  output logic       fa_B,
  output logic       fa_C_in,
  input  logic       fa_S,
  input  logic       fa_C,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] first_fail_vec,
  output logic [1:0] first_fail_resp
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;

  state_e        state_q, state_d;
  logic [2:0]    vec_q, vec_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [3:0]    err_q, err_d;
  logic [2:0]    ffv_q, ffv_d;
  logic [1:0]    ffr_q, ffr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;

  logic [3:0]    err_next;
  logic          capture;

  fa_bist_checker u_checker (
    .vec            (vec_q),
    .fa_s           (fa_S),
    .fa_c           (fa_C),
    .err_count      (err_q),
    .err_count_next (err_next),
    .capture        (capture)
  );

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    settle_d = settle_q;
    pcnt_d   = pcnt_q;
    err_d    = err_q;
    ffv_d    = ffv_q;
    ffr_d    = ffr_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = APPLY;
          vec_d    = 3'd0;
          settle_d = '0;
          pcnt_d   = '0;
          err_d    = 4'd0;
          ffv_d    = 3'd0;
          ffr_d    = 2'd0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          pass_d   = 1'b0;
        end
      end
      APPLY: begin
        if (settle_q == SW'(SETTLE - 1)) begin
          settle_d = '0;
          state_d  = SAMPLE;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      SAMPLE: begin
        err_d = err_next;
        if (capture) begin
          ffv_d = vec_q;
          ffr_d = {fa_C, fa_S};
        end
        // Last vector of a sweep either wraps into the next pass or ends the run.
        if (vec_q != 3'(NUM_VECTORS - 1)) begin
          vec_d   = vec_q + 3'd1;
          state_d = APPLY;
        end else if (pcnt_q != PW'(PASSES - 1)) begin
          vec_d   = 3'd0;
          pcnt_d  = pcnt_q + PW'(1);
          state_d = APPLY;
        end else begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_next == 4'd0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      vec_q    <= 3'd0;
      settle_q <= '0;
      pcnt_q   <= '0;
      err_q    <= 4'd0;
      ffv_q    <= 3'd0;
      ffr_q    <= 2'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      pcnt_q   <= pcnt_d;
      err_q    <= err_d;
      ffv_q    <= ffv_d;
      ffr_q    <= ffr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  assign {fa_A, fa_B, fa_C_in} = vec_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_fail_vec  = ffv_q;
  assign first_fail_resp = ffr_q;

endmodule
